spi_frame_ctrl: RTL and testbench

Command/frame sequencer between the SPI byte receiver and the LED datapath. It consumes the received byte stream (byte_rdy/byte_data) and decodes the first byte of each chip-select frame as a command. Payload bytes are steered into the LED pixel RAM or into the waveform configuration registers, and refresh/done pulses are issued to the LED output engine.

---
 rtl/spi_frame_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// spi_frame_ctrl
//
// Command/frame sequencer sitting between the SPI byte receiver and the LED
// datapath.  The first byte of every chip-select frame is decoded as a
// command.  The payload bytes that follow are either written to the LED
// pixel RAM (DATA_WR) or loaded into the waveform configuration registers
// (CONF_WR).  A REFRESH command kicks the LED output engine.  Any other
// command discards the rest of the frame.
//
// Ports
//   clk_in           system clock, single domain
//   rst_in           asynchronous, active-high reset
//   spi_cs_in        frame active (already synchronised to clk_in)
//   byte_rdy_in      one-cycle strobe, byte_data_in valid
//   byte_data_in     received byte
//   ram_wr_en_out    pixel RAM write strobe (one cycle per accepted byte)
//   ram_wr_addr_out  pixel RAM write address (wraps modulo 2^AW)
//   ram_wr_data_out  pixel RAM write data
//   cfg_t0h_out      configuration register 0 (T0H)
//   cfg_t1h_out      configuration register 1 (T1H)
//   cfg_period_out   configuration register 2 (bit period)
//   cfg_led_num_out  configuration register 3 (LED count)
//   refresh_out      one-cycle pulse: start LED output
//   data_done_out    one-cycle pulse: a DATA_WR frame has closed
//
// All outputs are registered: a byte strobed at edge N is reflected on the
// outputs during cycle N+1.
// ---------------------------------------------------------------------------
module spi_frame_ctrl #(
    parameter int          AW          = 8,
    parameter logic [7:0]  CFG_T0H_RST = 8'h10,
    parameter logic [7:0]  CFG_T1H_RST = 8'h20,
    parameter logic [7:0]  CFG_PRD_RST = 8'h40,
    parameter logic [7:0]  CFG_NUM_RST = 8'hFF
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          spi_cs_in,
    input  logic          byte_rdy_in,
    input  logic [7:0]    byte_data_in,
    output logic          ram_wr_en_out,
    output logic [AW-1:0] ram_wr_addr_out,
    output logic [7:0]    ram_wr_data_out,
    output logic [7:0]    cfg_t0h_out,
    output logic [7:0]    cfg_t1h_out,
    output logic [7:0]    cfg_period_out,
    output logic [7:0]    cfg_led_num_out,
    output logic          refresh_out,
    output logic          data_done_out
);

    // Command byte encodings
    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_DATA_WR = 8'h2C;
    localparam logic [7:0] CMD_REFRESH = 8'h2D;

    // cfg_idx saturates here; bytes arriving at this index are ignored
    localparam logic [2:0]    CFG_IDX_LAST = 3'd4;
    localparam logic [2:0]    CFG_IDX_ONE  = 3'd1;
    localparam logic [AW-1:0] PTR_ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE      = {{(AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CFG     = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    // Registered state
    state_t        state_r;
    logic [AW-1:0] wr_ptr_r;
    logic [2:0]    cfg_idx_r;
    logic          ram_wr_en_r;
    logic [AW-1:0] ram_wr_addr_r;
    logic [7:0]    ram_wr_data_r;
    logic [7:0]    cfg_t0h_r;
    logic [7:0]    cfg_t1h_r;
    logic [7:0]    cfg_period_r;
    logic [7:0]    cfg_led_num_r;
    logic          refresh_r;
    logic          data_done_r;

    // Next-state values
    state_t        state_nxt_s;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [2:0]    cfg_idx_nxt_s;
    logic          ram_wr_en_nxt_s;
    logic [AW-1:0] ram_wr_addr_nxt_s;
    logic [7:0]    ram_wr_data_nxt_s;
    logic [7:0]    cfg_t0h_nxt_s;
    logic [7:0]    cfg_t1h_nxt_s;
    logic [7:0]    cfg_period_nxt_s;
    logic [7:0]    cfg_led_num_nxt_s;
    logic          refresh_nxt_s;
    logic          data_done_nxt_s;

    // Next-state and output decode for the frame sequencer
    always_comb begin
        state_nxt_s       = state_r;
        wr_ptr_nxt_s      = wr_ptr_r;
        cfg_idx_nxt_s     = cfg_idx_r;
        ram_wr_en_nxt_s   = 1'b0;
        ram_wr_addr_nxt_s = ram_wr_addr_r;
        ram_wr_data_nxt_s = ram_wr_data_r;
        cfg_t0h_nxt_s     = cfg_t0h_r;
        cfg_t1h_nxt_s     = cfg_t1h_r;
        cfg_period_nxt_s  = cfg_period_r;
        cfg_led_num_nxt_s = cfg_led_num_r;
        refresh_nxt_s     = 1'b0;
        data_done_nxt_s   = 1'b0;

        if (!spi_cs_in) begin
            // Frame end wins over a coincident byte strobe: that byte is dropped.
            state_nxt_s = ST_IDLE;
            if (state_r == ST_DATA) begin
                data_done_nxt_s = 1'b1;
            end else begin
                data_done_nxt_s = 1'b0;
            end
        end else if (byte_rdy_in) begin
            case (state_r)
                ST_IDLE: begin
                    // First byte of the frame is the command
                    case (byte_data_in)
                        CMD_CONF_WR: begin
                            state_nxt_s   = ST_CFG;
                            cfg_idx_nxt_s = 3'd0;
                        end
                        CMD_DATA_WR: begin
                            state_nxt_s  = ST_DATA;
                            wr_ptr_nxt_s = PTR_ZERO;
                        end
                        CMD_REFRESH: begin
                            state_nxt_s   = ST_DISCARD;
                            refresh_nxt_s = 1'b1;
                        end
                        default: begin
                            state_nxt_s = ST_DISCARD;
                        end
                    endcase
                end
                ST_CFG: begin
                    if (cfg_idx_r < CFG_IDX_LAST) begin
                        case (cfg_idx_r[1:0])
                            2'd0:    cfg_t0h_nxt_s     = byte_data_in;
                            2'd1:    cfg_t1h_nxt_s     = byte_data_in;
                            2'd2:    cfg_period_nxt_s  = byte_data_in;
                            default: cfg_led_num_nxt_s = byte_data_in;
                        endcase
                        cfg_idx_nxt_s = cfg_idx_r + CFG_IDX_ONE;
                    end else begin
                        // Saturated: surplus configuration bytes are ignored
                        cfg_idx_nxt_s = cfg_idx_r;
                    end
                end
                ST_DATA: begin
                    ram_wr_en_nxt_s   = 1'b1;
                    ram_wr_addr_nxt_s = wr_ptr_r;
                    ram_wr_data_nxt_s = byte_data_in;
                    // Natural AW-bit overflow gives the modulo-2^AW wrap
                    wr_ptr_nxt_s      = wr_ptr_r + PTR_ONE;
                end
                ST_DISCARD: begin
                    state_nxt_s = ST_DISCARD;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: pointers, RAM write port, config and pulse outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_r      <= PTR_ZERO;
            cfg_idx_r     <= 3'd0;
            ram_wr_en_r   <= 1'b0;
            ram_wr_addr_r <= PTR_ZERO;
            ram_wr_data_r <= 8'h00;
            cfg_t0h_r     <= CFG_T0H_RST;
            cfg_t1h_r     <= CFG_T1H_RST;
            cfg_period_r  <= CFG_PRD_RST;
            cfg_led_num_r <= CFG_NUM_RST;
            refresh_r     <= 1'b0;
            data_done_r   <= 1'b0;
        end else begin
            wr_ptr_r      <= wr_ptr_nxt_s;
            cfg_idx_r     <= cfg_idx_nxt_s;
            ram_wr_en_r   <= ram_wr_en_nxt_s;
            ram_wr_addr_r <= ram_wr_addr_nxt_s;
            ram_wr_data_r <= ram_wr_data_nxt_s;
            cfg_t0h_r     <= cfg_t0h_nxt_s;
            cfg_t1h_r     <= cfg_t1h_nxt_s;
            cfg_period_r  <= cfg_period_nxt_s;
            cfg_led_num_r <= cfg_led_num_nxt_s;
            refresh_r     <= refresh_nxt_s;
            data_done_r   <= data_done_nxt_s;
        end
    end

    assign ram_wr_en_out   = ram_wr_en_r;
    assign ram_wr_addr_out = ram_wr_addr_r;
    assign ram_wr_data_out = ram_wr_data_r;
    assign cfg_t0h_out     = cfg_t0h_r;
    assign cfg_t1h_out     = cfg_t1h_r;
    assign cfg_period_out  = cfg_period_r;
    assign cfg_led_num_out = cfg_led_num_r;
    assign refresh_out     = refresh_r;
    assign data_done_out   = data_done_r;

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_frame_ctrl
//
// Drives whole SPI frames (command + payload) into spi_frame_ctrl and checks
// the observed RAM writes, pulses and config registers against a frame-level
// reference model: a CONF_WR frame loads up to four registers from its
// payload, a DATA_WR frame produces one write per payload byte at address
// (index mod 2^AW) plus one done pulse, a REFRESH frame produces one pulse.
// ---------------------------------------------------------------------------
module tb_spi_frame_ctrl;

    localparam int AW = 8;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          spi_cs = 1'b0;
    logic          byte_rdy = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          ram_wr_en;
    logic [AW-1:0] ram_wr_addr;
    logic [7:0]    ram_wr_data;
    logic [7:0]    cfg_t0h, cfg_t1h, cfg_period, cfg_led_num;
    logic          refresh;
    logic          data_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Observation records (filled by the monitor)
    logic [AW-1:0] cap_addr [$];
    logic [7:0]    cap_data [$];
    int            cap_cyc  [$];
    int            refresh_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;

    // Reference model state
    logic [7:0]    frame_q  [$];
    logic [AW-1:0] exp_addr [$];
    logic [7:0]    exp_data [$];
    int            exp_refresh = 0;
    int            exp_done = 0;
    logic [7:0]    m_cfg [4];
    int            cs_fall_cyc = 0;

    spi_frame_ctrl #(.AW(AW)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .spi_cs_in       (spi_cs),
        .byte_rdy_in     (byte_rdy),
        .byte_data_in    (byte_data),
        .ram_wr_en_out   (ram_wr_en),
        .ram_wr_addr_out (ram_wr_addr),
        .ram_wr_data_out (ram_wr_data),
        .cfg_t0h_out     (cfg_t0h),
        .cfg_t1h_out     (cfg_t1h),
        .cfg_period_out  (cfg_period),
        .cfg_led_num_out (cfg_led_num),
        .refresh_out     (refresh),
        .data_done_out   (data_done)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: sample outputs on the falling edge
    always @(negedge clk_in) begin
        if (ram_wr_en) begin
            cap_addr.push_back(ram_wr_addr);
            cap_data.push_back(ram_wr_data);
            cap_cyc.push_back(cyc);
        end
        if (refresh) refresh_cnt++;
        if (data_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_rdy  = 1'b1;
        byte_data = b;
        step();
        byte_rdy  = 1'b0;
    endtask

    task automatic clear_obs();
        cap_addr.delete(); cap_data.delete(); cap_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        refresh_cnt = 0; done_cnt = 0; done_cyc = -1;
        exp_refresh = 0; exp_done = 0;
    endtask

    task automatic set_model_defaults();
        m_cfg[0] = 8'h10; m_cfg[1] = 8'h20; m_cfg[2] = 8'h40; m_cfg[3] = 8'hFF;
    endtask

    // Frame-level model over the first n bytes of frame_q that were accepted
    task automatic model_frame(input int n);
        logic [AW-1:0] a;
        if (n == 0) return;
        case (frame_q[0])
            8'h2A: for (int i = 1; i < n && i <= 4; i++) m_cfg[i-1] = frame_q[i];
            8'h2C: begin
                for (int i = 1; i < n; i++) begin
                    a = AW'((i - 1) % (1 << AW));
                    exp_addr.push_back(a);
                    exp_data.push_back(frame_q[i]);
                end
                exp_done++;
            end
            8'h2D: exp_refresh++;
            default: ;
        endcase
    endtask

    // Send frame_q inside one chip-select window; drop_last lowers cs together
    // with the last byte strobe.
    task automatic drive_frame(input bit drop_last, input int max_gap);
        int n;
        int g;
        n = frame_q.size();
        spi_cs = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) step();
            if (drop_last && i == n - 1) begin
                spi_cs = 1'b0;
                cs_fall_cyc = cyc;
            end
            send_byte(frame_q[i]);
        end
        if (spi_cs) begin
            spi_cs = 1'b0;
            cs_fall_cyc = cyc;
            step();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) step();
        checks += 9;
        if (cfg_t0h !== 8'h10)     begin errors++; $display("FAIL rst_t0h got %h want 10", cfg_t0h); end
        if (cfg_t1h !== 8'h20)     begin errors++; $display("FAIL rst_t1h got %h want 20", cfg_t1h); end
        if (cfg_period !== 8'h40)  begin errors++; $display("FAIL rst_period got %h want 40", cfg_period); end
        if (cfg_led_num !== 8'hFF) begin errors++; $display("FAIL rst_led_num got %h want FF", cfg_led_num); end
        if (ram_wr_en !== 1'b0)    begin errors++; $display("FAIL rst_wr_en got %b want 0", ram_wr_en); end
        if (ram_wr_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", ram_wr_addr); end
        if (ram_wr_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", ram_wr_data); end
        if (refresh !== 1'b0)      begin errors++; $display("FAIL rst_refresh got %b want 0", refresh); end
        if (data_done !== 1'b0)    begin errors++; $display("FAIL rst_done got %b want 0", data_done); end
        rst_in = 1'b0;
        set_model_defaults();
        step();
    endtask

    task automatic test_conf_wr();
        clear_obs();
        frame_q = '{8'h2A, 8'h05, 8'h0A, 8'h30, 8'h3C, 8'h77};
        drive_frame(1'b0, 1);
        checks += 5;
        if (cfg_t0h !== 8'h05)     begin errors++; $display("FAIL conf_t0h got %h want 05", cfg_t0h); end
        if (cfg_t1h !== 8'h0A)     begin errors++; $display("FAIL conf_t1h got %h want 0A", cfg_t1h); end
        if (cfg_period !== 8'h30)  begin errors++; $display("FAIL conf_period got %h want 30", cfg_period); end
        if (cfg_led_num !== 8'h3C) begin errors++; $display("FAIL conf_led_num got %h want 3C", cfg_led_num); end
        if (cap_addr.size() != 0)  begin errors++; $display("FAIL conf_no_ram got %0d writes want 0", cap_addr.size()); end
        m_cfg[0] = 8'h05; m_cfg[1] = 8'h0A; m_cfg[2] = 8'h30; m_cfg[3] = 8'h3C;
    endtask

    task automatic test_data_wrap();
        clear_obs();
        frame_q.delete();
        frame_q.push_back(8'h2C);
        for (int i = 0; i < 300; i++) frame_q.push_back(8'(i & 8'hFF));
        drive_frame(1'b0, 0);
        model_frame(frame_q.size());
        checks++;
        if (cap_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL wrap_count got %0d want %0d", cap_addr.size(), exp_addr.size());
        end else begin
            for (int i = 0; i < exp_addr.size(); i++) begin
                checks++;
                if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i] || cap_cyc[i] != cap_cyc[0] + i) begin
                    errors++;
                    $display("FAIL wrap_wr[%0d] got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, cap_addr[i], cap_data[i],
                             cap_cyc[i], exp_addr[i], exp_data[i], cap_cyc[0] + i);
                end
            end
            checks += 2;
            if (cap_addr[256] !== 8'h00) begin errors++; $display("FAIL wrap_addr256 got %h want 00", cap_addr[256]); end
            if (cap_addr[299] !== 8'h2B) begin errors++; $display("FAIL wrap_addr299 got %h want 2B", cap_addr[299]); end
        end
        checks += 2;
        if (done_cnt != 1) begin errors++; $display("FAIL wrap_done_cnt got %0d want 1", done_cnt); end
        if (done_cyc != cs_fall_cyc + 1) begin errors++; $display("FAIL wrap_done_cyc got %0d want %0d", done_cyc, cs_fall_cyc + 1); end
    endtask

    task automatic test_refresh();
        clear_obs();
        frame_q = '{8'h2D, 8'h2C, 8'h11};
        drive_frame(1'b0, 1);
        checks += 4;
        if (refresh_cnt != 1)     begin errors++; $display("FAIL refresh_cnt got %0d want 1", refresh_cnt); end
        if (cap_addr.size() != 0) begin errors++; $display("FAIL refresh_no_ram got %0d want 0", cap_addr.size()); end
        if (done_cnt != 0)        begin errors++; $display("FAIL refresh_no_done got %0d want 0", done_cnt); end
        if ({cfg_t0h, cfg_t1h, cfg_period, cfg_led_num} !== {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]}) begin
            errors++; $display("FAIL refresh_cfg got %h%h%h%h", cfg_t0h, cfg_t1h, cfg_period, cfg_led_num);
        end
        clear_obs();
        frame_q = '{8'h2C, 8'hA5, 8'h5A};
        drive_frame(1'b0, 0);
        checks += 3;
        if (cap_addr.size() != 2) begin
            errors++; $display("FAIL refresh_next_count got %0d want 2", cap_addr.size());
        end else if (cap_addr[0] !== 8'h00 || cap_data[0] !== 8'hA5 || cap_addr[1] !== 8'h01 || cap_data[1] !== 8'h5A) begin
            errors++; $display("FAIL refresh_next_wr got %h/%h %h/%h", cap_addr[0], cap_data[0], cap_addr[1], cap_data[1]);
        end
        if (done_cnt != 1)    begin errors++; $display("FAIL refresh_next_done got %0d want 1", done_cnt); end
        if (refresh_cnt != 0) begin errors++; $display("FAIL refresh_next_refresh got %0d want 0", refresh_cnt); end
    endtask

    task automatic test_unknown();
        clear_obs();
        frame_q = '{8'h55, 8'h2A, 8'h01};
        drive_frame(1'b0, 1);
        checks += 3;
        if ({cfg_t0h, cfg_t1h, cfg_period, cfg_led_num} !== {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]}) begin
            errors++; $display("FAIL unknown_cfg got %h%h%h%h", cfg_t0h, cfg_t1h, cfg_period, cfg_led_num);
        end
        if (done_cnt != 0)    begin errors++; $display("FAIL unknown_done got %0d want 0", done_cnt); end
        if (cap_addr.size() != 0 || refresh_cnt != 0) begin
            errors++; $display("FAIL unknown_side got %0d writes %0d refresh want 0", cap_addr.size(), refresh_cnt);
        end
    endtask

    task automatic test_cs_drop_data();
        clear_obs();
        frame_q = '{8'h2C, 8'h11, 8'h22, 8'h33, 8'h44};
        drive_frame(1'b1, 0);
        model_frame(frame_q.size() - 1);
        checks += 3;
        if (cap_addr.size() != 3) begin
            errors++; $display("FAIL csdrop_count got %0d want 3", cap_addr.size());
        end else if (cap_data[2] !== 8'h33 || cap_addr[2] !== 8'h02) begin
            errors++; $display("FAIL csdrop_last got %h@%h want 33@02", cap_data[2], cap_addr[2]);
        end
        if (done_cnt != 1) begin errors++; $display("FAIL csdrop_done got %0d want 1", done_cnt); end
        if (done_cyc != cs_fall_cyc + 1) begin errors++; $display("FAIL csdrop_done_cyc got %0d want %0d", done_cyc, cs_fall_cyc + 1); end
    endtask

    task automatic test_reset_mid_data();
        clear_obs();
        spi_cs = 1'b1;
        step();
        send_byte(8'h2C);
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i));
        step();
        rst_in = 1'b1;
        #1;
        checks += 2;
        if (ram_wr_en !== 1'b0 || ram_wr_addr !== 8'h00) begin
            errors++; $display("FAIL rstmid_wr got en=%b a=%h want 0/00", ram_wr_en, ram_wr_addr);
        end
        if ({cfg_t0h, cfg_t1h, cfg_period, cfg_led_num} !== 32'h102040FF) begin
            errors++; $display("FAIL rstmid_cfg got %h%h%h%h want 102040FF", cfg_t0h, cfg_t1h, cfg_period, cfg_led_num);
        end
        for (int i = 0; i < 3; i++) send_byte(8'hEE);
        rst_in = 1'b0;
        set_model_defaults();
        // Frame still open: its next byte is a command
        send_byte(8'h2D);
        send_byte(8'h11);
        spi_cs = 1'b0;
        repeat (3) step();
        checks += 3;
        if (cap_addr.size() != 5) begin
            errors++; $display("FAIL rstmid_count got %0d want 5", cap_addr.size());
        end else if (cap_addr[4] !== 8'h04 || cap_data[4] !== 8'hC4) begin
            errors++; $display("FAIL rstmid_last got %h@%h want C4@04", cap_data[4], cap_addr[4]);
        end
        if (refresh_cnt != 1) begin errors++; $display("FAIL rstmid_refresh got %0d want 1", refresh_cnt); end
        if (done_cnt != 0)    begin errors++; $display("FAIL rstmid_done got %0d want 0", done_cnt); end
        clear_obs();
        frame_q = '{8'h2C, 8'h9A, 8'h9B, 8'h9C};
        drive_frame(1'b0, 0);
        checks++;
        if (cap_addr.size() != 3 || cap_addr[0] !== 8'h00 || cap_addr[2] !== 8'h02 || cap_data[0] !== 8'h9A) begin
            errors++; $display("FAIL rstmid_restart got %0d writes first=%h", cap_addr.size(),
                               (cap_addr.size() > 0) ? cap_addr[0] : 8'hXX);
        end
    endtask

    task automatic test_random();
        logic [7:0] cmds [4];
        int  len;
        bit  drop;
        cmds[0] = 8'h2A; cmds[1] = 8'h2C; cmds[2] = 8'h2D;
        for (int f = 0; f < 40; f++) begin
            clear_obs();
            cmds[3] = 8'($urandom_range(0, 255));
            frame_q.delete();
            frame_q.push_back(cmds[$urandom_range(0, 3)]);
            len = $urandom_range(0, 12);
            for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom_range(0, 255)));
            drop = ($urandom_range(0, 4) == 0);
            drive_frame(drop, 2);
            model_frame(frame_q.size() - (drop ? 1 : 0));
            checks += 4;
            if (cap_addr.size() != exp_addr.size()) begin
                errors++; $display("FAIL rnd%0d_count got %0d want %0d", f, cap_addr.size(), exp_addr.size());
            end else begin
                for (int i = 0; i < exp_addr.size(); i++) begin
                    if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_wr[%0d] got %h@%h want %h@%h", f, i, cap_data[i], cap_addr[i], exp_data[i], exp_addr[i]);
                    end
                end
            end
            if (refresh_cnt != exp_refresh) begin errors++; $display("FAIL rnd%0d_refresh got %0d want %0d", f, refresh_cnt, exp_refresh); end
            if (done_cnt != exp_done) begin
                errors++; $display("FAIL rnd%0d_done got %0d want %0d", f, done_cnt, exp_done);
            end else if (exp_done == 1 && done_cyc != cs_fall_cyc + 1) begin
                errors++; $display("FAIL rnd%0d_done_cyc got %0d want %0d", f, done_cyc, cs_fall_cyc + 1);
            end
            if ({cfg_t0h, cfg_t1h, cfg_period, cfg_led_num} !== {m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]}) begin
                errors++;
                $display("FAIL rnd%0d_cfg got %h%h%h%h want %h%h%h%h", f, cfg_t0h, cfg_t1h, cfg_period, cfg_led_num,
                         m_cfg[0], m_cfg[1], m_cfg[2], m_cfg[3]);
            end
        end
    endtask

    initial begin
        set_model_defaults();
        #2;
        test_reset();
        test_conf_wr();
        test_data_wrap();
        test_refresh();
        test_unknown();
        test_cs_drop_data();
        test_reset_mid_data();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
